// File: rtl/serial_negate_mc.sv
// Multi-lane bit-serial two's-complement negator (LSB first), one shared bit counter.
// Optional overflow flag for -2^(WIDTH-1) inputs is compiled in by SERIAL_NEGATE_OVF_DETECT_EN.
module serial_negate_mc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_clr,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] x,
  input  logic [CHANNELS-1:0] neg_en,
  output logic [CHANNELS-1:0] z,
  output logic                out_valid,
  output logic                out_last
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
  ,
  output logic [CHANNELS-1:0] ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } state_t;

  logic [CW-1:0]       cnt_q, cnt_d;
  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d, mode_eff;
  logic [CHANNELS-1:0] z_d;
  logic                out_valid_d, out_last_d;
  logic                at_first, at_last;
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
  logic [CHANNELS-1:0] ovf_d;
`endif

  // Bit 0 uses neg_en directly; later bits use the mode latched with bit 0.
  always_comb begin
    at_first = (cnt_q == '0);
    at_last  = (cnt_q == LAST_IDX);
    mode_eff = at_first ? neg_en : mode_q;
  end

  // Next state and output values for the counter and every lane FSM.
  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    state_d     = state_q;
    z_d         = z;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
    ovf_d       = '0;
`endif
    if (sync_clr) begin
      cnt_d = '0;
      for (int i = 0; i < int'(CHANNELS); i++) state_d[i] = COPY;
    end else if (in_valid) begin
      cnt_d       = at_last ? '0 : cnt_q + CW'(1);
      out_valid_d = 1'b1;
      out_last_d  = at_last;
      if (at_first) mode_d = neg_en;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (state_q[i] == COPY) begin
          z_d[i] = x[i];
          if (mode_eff[i] && x[i]) state_d[i] = INVERT;
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
          ovf_d[i] = mode_eff[i] & x[i] & at_last;
`else
          // overflow detection compiled out
`endif
        end else begin
          z_d[i] = ~x[i];
        end
        if (at_last) state_d[i] = COPY;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mode_q    <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) state_q[i] <= COPY;
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
      ovf       <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      z         <= z_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      state_q   <= state_d;
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
      ovf       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_negate_mc.sv
// Scoreboard bench for serial_negate_mc, WIDTH=8, CHANNELS=2, directed vectors.
module tb_serial_negate_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync_clr;
  logic       in_valid;
  logic [1:0] x;
  logic [1:0] neg_en;
  logic [1:0] z;
  logic       out_valid;
  logic       out_last;
  logic [1:0] ovf_w;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] z;
    logic       last;
    logic [1:0] ovf;
  } exp_t;

  exp_t q[$];

  serial_negate_mc #(.WIDTH(8), .CHANNELS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .x         (x),
    .neg_en    (neg_en),
    .z         (z),
    .out_valid (out_valid),
    .out_last  (out_last)
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
    ,
    .ovf       (ovf_w)
`endif
  );

`ifndef SERIAL_NEGATE_OVF_DETECT_EN
  assign ovf_w = 2'b00;
`endif

  always #5 clk = ~clk;

  // Monitor: every valid output bit is checked against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL out_bit: unexpected output z=%b last=%b, required none", z, out_last);
      end else begin
        e = q.pop_front();
        if (z !== e.z || out_last !== e.last || ovf_w !== e.ovf) begin
          fails++;
          $display("FAIL out_bit: got z=%b last=%b ovf=%b, required z=%b last=%b ovf=%b",
                   z, out_last, ovf_w, e.z, e.last, e.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic [1:0] xb, input exp_t e, input bit push);
    in_valid = 1'b1;
    x        = xb;
    if (push) q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Sends bits lo..hi of a word on both lanes, expecting bits of e0/e1.
  task automatic send_bits(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [1:0] ov, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_t e;
      e.z    = {e1[i], e0[i]};
      e.last = (i == 7);
      e.ovf  = (i == 7) ? ov : 2'b00;
      send_bit({a1[i], a0[i]}, e, 1'b1);
    end
  endtask

  task automatic send_word(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] ov);
    send_bits(a0, a1, e0, e1, ov, 0, 7);
  endtask

  task automatic drain();
    tick();
    tick();
    chk("drain_empty", 8'(q.size()), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    x        = 2'b00;
    neg_en   = 2'b00;
    #1;
    chk("reset_z", {6'd0, z}, 8'd0);
    chk("reset_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_last", {7'd0, out_last}, 8'd0);
    chk("reset_ovf", {6'd0, ovf_w}, 8'd0);
    #11 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_valid", {7'd0, out_valid}, 8'd0);

    // Basic negate on both lanes.
    neg_en = 2'b11;
    send_word(8'h0C, 8'hA5, 8'hF4, 8'h5B, 2'b00);
    drain();

    // Mixed modes, back-to-back words.
    neg_en = 2'b01;
    send_word(8'h01, 8'h01, 8'hFF, 8'h01, 2'b00);
    send_word(8'h05, 8'h05, 8'hFB, 8'h05, 2'b00);
    drain();

    // Gap after bit 3 with neg_en toggling; new mode only applies to the next word.
    neg_en = 2'b11;
    send_bits(8'h0C, 8'h0C, 8'hF4, 8'hF4, 2'b00, 0, 3);
    for (int g = 0; g < 3; g++) begin
      neg_en = ~neg_en;
      tick();
      chk("gap_valid", {7'd0, out_valid}, 8'd0);
    end
    send_bits(8'h0C, 8'h0C, 8'hF4, 8'hF4, 2'b00, 4, 7);
    send_word(8'h37, 8'h37, 8'h37, 8'h37, 2'b00);
    drain();

    // sync_clr together with in_valid at bit 4 drops that bit and restarts.
    neg_en = 2'b11;
    send_bits(8'h0C, 8'h0C, 8'hF4, 8'hF4, 2'b00, 0, 3);
    sync_clr = 1'b1;
    send_bit(2'b00, '0, 1'b0);
    sync_clr = 1'b0;
    chk("clr_valid", {7'd0, out_valid}, 8'd0);
    chk("clr_last", {7'd0, out_last}, 8'd0);
    send_word(8'h03, 8'h03, 8'hFD, 8'hFD, 2'b00);
    drain();

    // Overflow boundary: -128 in negate mode, and in pass-through mode.
`ifdef SERIAL_NEGATE_OVF_DETECT_EN
    neg_en = 2'b11;
    send_word(8'h80, 8'h00, 8'h80, 8'h00, 2'b01);
    neg_en = 2'b01;
    send_word(8'h00, 8'h80, 8'h00, 8'h80, 2'b00);
`else
    neg_en = 2'b11;
    send_word(8'h80, 8'h00, 8'h80, 8'h00, 2'b00);
    neg_en = 2'b01;
    send_word(8'h00, 8'h80, 8'h00, 8'h80, 2'b00);
`endif
    drain();

    // Async reset between edges at bit 5.
    neg_en = 2'b11;
    send_bits(8'h0C, 8'h0C, 8'hF4, 8'hF4, 2'b00, 0, 4);
    in_valid = 1'b1;
    x        = 2'b00;
    @(negedge clk);
    #1;
    chk("pre_rst_z", {6'd0, z}, 8'h03);
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("rst_z", {6'd0, z}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_last", {7'd0, out_last}, 8'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {7'd0, out_valid}, 8'd0);
    send_word(8'h02, 8'h02, 8'hFE, 8'hFE, 2'b00);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_negate_mc.md
SERIAL_NEGATE_MC -- requirements
Module: serial_negate_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving bits per serial word (legal range 2..64).
REQ-002 The block SHALL have parameter CHANNELS, default 1, giving the number of independent serial lanes (legal range 1..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sync_clr, input, 1 bit: synchronous word restart.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the x bits are valid this cycle.
REQ-007 The block SHALL have port x, input, CHANNELS bits: one serial input bit per lane, LSB first.
REQ-008 The block SHALL have port neg_en, input, CHANNELS bits: per-lane mode, 1 = negate, 0 = pass-through.
REQ-009 The block SHALL have port z, output, CHANNELS bits: the registered serial result per lane.
REQ-010 The block SHALL have port out_valid, output, 1 bit: z is valid this cycle.
REQ-011 The block SHALL have port out_last, output, 1 bit: z carries bit WIDTH-1 of a word.
REQ-012 The block SHALL have port ovf, output, CHANNELS bits; this port exists only when the macro in REQ-029 is defined.

Function
REQ-013 The block SHALL compute the two's-complement negation of each lane's WIDTH-bit word serially, LSB first.
REQ-014 Each lane SHALL have a two-state FSM, COPY and INVERT; at the start of every word each lane is in COPY.
REQ-015 In COPY, z SHALL equal x, and the lane SHALL move to INVERT on the first accepted x=1.
REQ-016 In INVERT, z SHALL equal ~x, and the lane SHALL stay in INVERT until the word ends.
REQ-017 A shared bit counter of width $clog2(WIDTH) SHALL advance on each accepted bit (in_valid=1) and wrap from WIDTH-1 to 0.
REQ-018 On wrap, every lane SHALL return to COPY, so consecutive words need no idle cycle between them.
REQ-019 neg_en for each lane SHALL be sampled when counter=0 and held for the whole word; a change in mid-word SHALL have no effect until the next word.
REQ-020 A lane whose held mode is 0 SHALL output z=x for the whole word, and its FSM SHALL remain in COPY.
REQ-021 z, out_valid and out_last SHALL be registered, giving a latency of exactly 1 cycle from accepted bit to output.
REQ-022 out_last SHALL be 1 exactly when the output bit was accepted with counter=WIDTH-1.
REQ-023 When in_valid=0: out_valid SHALL go to 0 next cycle, and z, the counter and the FSMs SHALL hold; gaps inside a word are legal.
REQ-024 sync_clr SHALL have priority over in_valid in the same cycle: counter goes to 0, lanes go to COPY, out_valid, out_last and ovf go to 0 next cycle, and the concurrent input bit is discarded.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force: z=0, out_valid=0, out_last=0, ovf=0, counter=0, all lanes in COPY, all held modes = 0.
REQ-026 Reset asserted in mid-word SHALL abandon the partial word, and the first accepted bit after release SHALL be treated as bit 0.
REQ-027 Release of rst_n SHALL take effect on a clk edge with no output glitch; out_valid SHALL stay 0 until the first accepted bit.

Configuration
REQ-028 The overflow-detection feature SHALL be compiled in or out by a single macro.
REQ-029 The macro SHALL be SERIAL_NEGATE_OVF_DETECT_EN.
REQ-030 With SERIAL_NEGATE_OVF_DETECT_EN defined: ovf[i] SHALL be 1 alongside out_last when lane i has held mode 1, has remained in COPY through bit WIDTH-2, and bit WIDTH-1 is 1 (input = -2^(WIDTH-1)).
REQ-031 With SERIAL_NEGATE_OVF_DETECT_EN defined, ovf SHALL be 0 at all other times.
REQ-032 Without SERIAL_NEGATE_OVF_DETECT_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8 unless noted)
REQ-033 Scenario, basic negate: lane 0 has neg_en=1; stream 0x0C LSB first (0,0,1,1,0,0,0,0) -> z = 0,0,1,0,1,1,1,1 (0xF4), one cycle late, out_last on the 8th bit.
REQ-034 Scenario, mixed modes with back-to-back words: CHANNELS=2, neg_en=2'b01; lanes send 0x01 then 0x05 -> lane 0 gives 0xFF then 0xFB; lane 1 gives 0x01 then 0x05; the second word has no idle cycle and starts in COPY.
REQ-035 Scenario, gaps and mid-word mode change: drop in_valid for 3 cycles after bit 3 of 0x0C, and toggle neg_en during the gap -> result is still 0xF4, and out_valid=0 during the gap.
REQ-036 Scenario, sync_clr: assert sync_clr together with in_valid at bit 4 -> that bit is dropped, the next bit is treated as bit 0, and 0x03 then gives 0xFD.
REQ-037 Scenario, overflow (macro defined): input 0x80 -> z = 0x80 and ovf=1 with out_last; input 0x00 -> z = 0x00 and ovf=0.
REQ-038 Scenario, async reset: pull rst_n low between clock edges at bit 5 -> all outputs go to 0 immediately; after release, 0x02 gives 0xFE.
